// File: rtl/dbg_scan_tx.sv
// Debug observation port scanner: steps the output select, captures the
// LED word and streams a 5-byte record per select over an 8N1 line.
module dbg_scan_tx #(
  parameter int CLKS_PER_BIT  = 16,
  parameter int NUM_SEL       = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset_n,
  input  logic        DBG_start,
  input  logic [26:0] DBG_leds_in,
  output logic [7:0]  DBG_sel_out,
  output logic        DBG_tx,
  output logic        DBG_busy,
  output logic        DBG_done,
  output logic [7:0]  DBG_frame_cnt
);

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] LAST_SEL  = 8'(NUM_SEL - 1);
  localparam logic [3:0] SETTLE_LAST =
    4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  // NEXT is folded into the final TX edge, so it has no encoding
  typedef enum logic [1:0] {
    IDLE, SETTLE, CAPTURE, TX
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  settle_cnt;
  logic [7:0]  baud_cnt;
  logic [3:0]  bit_idx;
  logic [2:0]  byte_idx;
  logic [26:0] cap;
  logic [7:0]  cur_byte;
  logic        settle_done;
  logic        slot_end;
  logic        last_slot;
  logic        last_byte;
  logic        rec_end;
  logic        more_sel;
  logic        tx_next;

  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign slot_end    = (baud_cnt == BAUD_LAST);
  assign last_slot   = (bit_idx == 4'd9);
  assign last_byte   = (byte_idx == 3'd4);
  assign rec_end     = slot_end && last_slot && last_byte;
  assign more_sel    = (DBG_sel_out < LAST_SEL);

  always_comb begin
    cur_byte = {5'b0, cap[26:24]};
    unique case (byte_idx)
      3'd0:    cur_byte = DBG_sel_out;
      3'd1:    cur_byte = cap[7:0];
      3'd2:    cur_byte = cap[15:8];
      3'd3:    cur_byte = cap[23:16];
      default: cur_byte = {5'b0, cap[26:24]};
    endcase
  end

  // level for the slot after bit_idx: data bit, or stop after bit 7
  assign tx_next = (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (DBG_start) state_d = SETTLE;
      SETTLE:  if (settle_done) state_d = CAPTURE;
      CAPTURE: state_d = TX;
      TX:      if (rec_end) state_d = more_sel ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    DBG_busy = (state_q != IDLE);
  end

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset_n) begin
      DBG_tx        <= 1'b1;
      DBG_done      <= 1'b0;
      DBG_sel_out   <= 8'd0;
      DBG_frame_cnt <= 8'd0;
      settle_cnt    <= 4'd0;
      baud_cnt      <= 8'd0;
      bit_idx       <= 4'd0;
      byte_idx      <= 3'd0;
      cap           <= 27'd0;
    end else begin
      DBG_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          DBG_tx <= 1'b1;
          if (DBG_start) begin
            DBG_sel_out <= 8'd0;
            settle_cnt  <= 4'd0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
        end
        CAPTURE: begin
          cap      <= DBG_leds_in;
          baud_cnt <= 8'd0;
          bit_idx  <= 4'd0;
          byte_idx <= 3'd0;
          DBG_tx   <= 1'b0;
        end
        TX: begin
          if (!slot_end) begin
            baud_cnt <= baud_cnt + 8'd1;
          end else begin
            baud_cnt <= 8'd0;
            if (!last_slot) begin
              bit_idx <= bit_idx + 4'd1;
              DBG_tx  <= tx_next;
            end else if (!last_byte) begin
              bit_idx  <= 4'd0;
              byte_idx <= byte_idx + 3'd1;
              DBG_tx   <= 1'b0;
            end else begin
              DBG_tx <= 1'b1;
              if (more_sel) begin
                DBG_sel_out <= DBG_sel_out + 8'd1;
                settle_cnt  <= 4'd0;
              end else begin
                DBG_done      <= 1'b1;
                DBG_frame_cnt <= DBG_frame_cnt + 8'd1;
              end
            end
          end
        end
        default: DBG_tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: doc/dbg_scan_tx.md
Name: dbg_scan_tx

Overview:
- Host-side reader for the processor's debug observation port. It drives the 8-bit output-select bus and captures the 27-bit LED word for each selection.
- Each captured word is serialized onto a single UART-style 8N1 line, so one scan dumps the whole processor debug state (instruction, register read, ALU result, status, DMEM data, control, ALU control, PC/EPC).
- Sits between the processor top level (its SYS_output_sel / SYS_leds pins) and an external serial pin.

Parameters:
- CLKS_PER_BIT, 16, SYS_clk cycles per serial bit; legal range 1..255.
- NUM_SEL, 8, number of select values scanned (0..NUM_SEL-1); legal range 1..256.
- SETTLE_CYCLES, 2, cycles DBG_sel_out is held before DBG_leds_in is sampled; legal range 0..15.

Ports:
- SYS_clk  in  1  single clock; all logic on rising edge.
- SYS_reset_n  in  1  synchronous active-low reset.
- DBG_start  in  1  scan request; sampled only in IDLE.
- DBG_leds_in  in  27  observed word; connects to the processor's SYS_leds.
- DBG_sel_out  out  8  select value; connects to the processor's SYS_output_sel.
- DBG_tx  out  1  serial output, idle high, 8N1, LSB first.
- DBG_busy  out  1  high from scan acceptance through the last stop bit.
- DBG_done  out  1  one-cycle pulse when a scan completes.
- DBG_frame_cnt  out  8  count of completed scans.

Behaviour:
- Reset: synchronous. SYS_reset_n low at a rising edge forces state=IDLE, DBG_tx=1, DBG_busy=0, DBG_done=0, DBG_sel_out=0, DBG_frame_cnt=0, and clears all internal counters. Reset overrides every other event, including mid-bit and mid-scan; DBG_tx is 1 after that edge, so no partial byte continues.
- States: IDLE, SETTLE, CAPTURE, TX, NEXT.
- IDLE:
  - DBG_tx=1, DBG_busy=0.
  - DBG_start=1 at edge e gives, after e: state=SETTLE, DBG_busy=1, DBG_sel_out=0, settle counter=0.
- SETTLE:
  - DBG_sel_out is held stable.
  - After SETTLE_CYCLES cycles go to CAPTURE. With SETTLE_CYCLES=0, go to CAPTURE on the first edge.
- CAPTURE (1 cycle):
  - Latch DBG_leds_in into the 27-bit capture register.
  - Build the 5-byte record: B0=DBG_sel_out, B1=cap[7:0], B2=cap[15:8], B3=cap[23:16], B4={5'b0,cap[26:24]}.
  - Go to TX with byte index=0 and bit index=0.
- TX:
  - Each byte is 10 bit slots: start (0), data bits 0..7, stop (1).
  - Each slot lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1.
  - DBG_tx changes only at slot boundaries.
  - Bytes are sent back-to-back with no idle gap; a byte's stop slot is followed immediately by the next start slot.
  - After the B4 stop slot, go to NEXT.
- NEXT (0 cycles, folded into the last TX edge):
  - If DBG_sel_out < NUM_SEL-1: DBG_sel_out+1, go to SETTLE.
  - Otherwise: go to IDLE, DBG_busy=0, DBG_done=1 for one cycle, DBG_frame_cnt+1.
  - DBG_tx stays 1 (idle level) during SETTLE/CAPTURE of the next select.
- Per-select duration is SETTLE_CYCLES + 1 + 50*CLKS_PER_BIT cycles. Scan duration is NUM_SEL times that.
- DBG_start while busy is ignored; no queuing.
- DBG_start high on the same edge that DBG_done asserts is ignored. A new scan needs DBG_start sampled in IDLE on a later edge.
- DBG_frame_cnt wraps 255 -> 0.
- DBG_sel_out is zero-extended when NUM_SEL-1 < 255.
- DBG_leds_in is sampled only in CAPTURE; changes at other times have no effect.

Test Plan:
- Reset: SYS_reset_n low for 3 cycles mid-scan -> next edge DBG_tx=1, DBG_busy=0, DBG_sel_out=0, DBG_frame_cnt=0, DBG_done=0.
- Single scan, CLKS_PER_BIT=4, NUM_SEL=8, SETTLE_CYCLES=2, DBG_leds_in=27'h3ABCDEF constant; pulse DBG_start -> serial monitor decodes 40 bytes, 8 records of {sel, EF, CD, AB, 03} with sel=00..07.
- Busy and done timing, same config:
  - DBG_busy high for exactly 8*(3+200)=1624 cycles.
  - First start-bit falling edge occurs 3 cycles after DBG_busy rises.
  - DBG_done is one 1-cycle pulse; DBG_frame_cnt=1.
- Select-dependent data: model DBG_leds_in = sel*27'h0111111 combinationally -> record for sel=5 is {05, 55, 55, 55, 00}. Changing DBG_leds_in during TX does not alter the bytes sent.
- Start while busy: pulse DBG_start at cycles 10, 500 and 1623 of a scan -> exactly one scan, DBG_frame_cnt increments by 1.
- Wrap: CLKS_PER_BIT=1, NUM_SEL=1, SETTLE_CYCLES=0; run 256 back-to-back scans -> DBG_frame_cnt goes 255 -> 0. Reset asserted mid-byte, then DBG_start -> clean scan starting at sel 0.
